// File: rtl/path_delay_pkg.sv
// path_delay_pkg: shared types and helpers for the path-delay scheduler.
package path_delay_pkg;
  localparam int DW_DEFAULT = 4;
  localparam int MIN_DELAY = 1;
  typedef enum logic {TRANSPORT, INERTIAL} delay_mode_e;
  typedef struct packed {
    logic [DW_DEFAULT:0] due;
    logic                val;
  } delay_evt_t;
  function automatic logic [DW_DEFAULT-1:0] eff_delay(input logic [DW_DEFAULT-1:0] cfg);
    return (cfg < DW_DEFAULT'(MIN_DELAY)) ? DW_DEFAULT'(MIN_DELAY) : cfg;
  endfunction
endpackage

// File: rtl/path_delay_sched_if.sv
// path_delay_sched_if: stimulus/consumer bundle around the path-delay scheduler.
interface path_delay_sched_if #(parameter int DW = 4, parameter int DEPTH = 8);
  import path_delay_pkg::*;
  logic                   in_sig;
  delay_mode_e            mode;
  logic [DW-1:0]          delay_cfg;
  logic                   ovf_clr;
  logic                   out_sig;
  logic                   out_known;
  logic                   busy;
  logic [$clog2(DEPTH):0] pending;
  logic                   ovf;
  modport master (output in_sig, mode, delay_cfg, ovf_clr,
                  input  out_sig, out_known, busy, pending, ovf);
  modport slave  (input  in_sig, mode, delay_cfg, ovf_clr,
                  output out_sig, out_known, busy, pending, ovf);
endinterface

// File: rtl/evt_fifo.sv
// evt_fifo: event queue with same-cycle push/pop (even when full) and a flush
// that can coexist with a push, leaving only the new entry.
module evt_fifo
  import path_delay_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  delay_evt_t din_i,
  output delay_evt_t head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] count_o
);
  delay_evt_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop || flush_i);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= flush_i ? wr_q : rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= flush_i ? (AW+1)'(do_push) : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/path_delay_sched.sv
// path_delay_sched: replays transitions of in_sig on out_sig a configurable
// number of cycles later, in transport or inertial fashion.
module path_delay_sched
  import path_delay_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  path_delay_sched_if.slave pd
);
  localparam int AW = $clog2(DEPTH);
  logic [DW:0] now_q;
  logic last_q, last_vld_q, out_q, known_q, ovf_q;
  logic [DW-1:0] act_d_q, d_use;
  delay_mode_e act_mode_q, mode_use;
  delay_evt_t head, new_evt;
  logic full, empty, evt, pop, push, flush, drop, out_nxt;
  logic [AW:0] count;
  always_comb begin
    // an idle queue lets the live config apply to the event that wakes it
    d_use = empty ? eff_delay(pd.delay_cfg) : act_d_q;
    mode_use = empty ? pd.mode : act_mode_q;
    evt = !last_vld_q || pd.in_sig != last_q;
    pop = !empty && now_q == head.due;
    out_nxt = pop ? head.val : out_q;
    new_evt = '{due: now_q + (DW+1)'(d_use), val: pd.in_sig};
    flush = mode_use == INERTIAL && evt && !empty;
    push = evt && (mode_use == INERTIAL ? pd.in_sig != out_nxt : (!full || pop));
    drop = evt && mode_use == TRANSPORT && full && !pop;
  end
  evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(flush),
    .din_i(new_evt), .head_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      now_q <= '0;
      last_q <= 1'b0;
      last_vld_q <= 1'b0;
      out_q <= 1'b0;
      known_q <= 1'b0;
      ovf_q <= 1'b0;
      act_d_q <= DW'(MIN_DELAY);
      act_mode_q <= TRANSPORT;
    end else begin
      now_q <= now_q + 1'b1;
      last_q <= pd.in_sig;
      last_vld_q <= 1'b1;
      out_q <= out_nxt;
      known_q <= known_q | pop;
      ovf_q <= drop | (ovf_q & ~pd.ovf_clr);
      if (empty) begin
        act_d_q <= d_use;
        act_mode_q <= mode_use;
      end
    end
  assign pd.out_sig = out_q;
  assign pd.out_known = known_q;
  assign pd.busy = !empty;
  assign pd.pending = count;
  assign pd.ovf = ovf_q;
endmodule

// File: tb/tb_path_delay_sched.sv
// tb_path_delay_sched: directed scenarios with a scoreboard of expected output edges.
module tb_path_delay_sched;
  import path_delay_pkg::*;
  typedef struct {int ed; logic val;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [1:0] prev = 2'b00;
  exp_t sb[$];
  path_delay_sched_if #(.DW(4), .DEPTH(8)) pd ();
  path_delay_sched #(.DW(4), .DEPTH(8)) dut (.clk(clk), .rst(rst), .pd(pd));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic expect_at(input int ed, input logic v);
    sb.push_back('{ed, v});
  endtask
  task automatic tick();
    exp_t e;
    e = '{-1, 1'bx};
    @(posedge clk);
    #1;
    if ({pd.out_known, pd.out_sig} !== prev) begin
      if (sb.size() != 0) e = sb.pop_front();
      chk("out_edge", k, e.ed);
      chk("out_val", pd.out_sig, e.val);
      chk("out_known", pd.out_known, 1);
    end
    prev = {pd.out_known, pd.out_sig};
    k++;
  endtask
  task automatic run_to(input int n);
    while (k < n) tick();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_out"}, pd.out_sig, 0);
    chk({tag, "_known"}, pd.out_known, 0);
    chk({tag, "_busy"}, pd.busy, 0);
    chk({tag, "_pending"}, pd.pending, 0);
    chk({tag, "_ovf"}, pd.ovf, 0);
  endtask
  initial begin
    pd.in_sig = 1'b0;
    pd.mode = TRANSPORT;
    pd.delay_cfg = 4'd2;
    pd.ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    expect_at(2, 1'b0);
    tick();
    chk("known_e0", pd.out_known, 0);
    tick();
    chk("known_e1", pd.out_known, 0);
    run_to(10);
    pd.in_sig = 1'b1;
    expect_at(12, 1'b1);
    run_to(14);
    pd.delay_cfg = 4'd3;
    run_to(15);
    pd.in_sig = 1'b0;
    expect_at(18, 1'b0);
    run_to(20);
    pd.in_sig = 1'b1;
    expect_at(23, 1'b1);
    tick();
    chk("tp_pend1", pd.pending, 1);
    pd.in_sig = 1'b0;
    expect_at(24, 1'b0);
    tick();
    chk("tp_pend2", pd.pending, 2);
    run_to(26);
    chk("tp_drain", pd.busy, 0);
    pd.mode = INERTIAL;
    run_to(30);
    pd.in_sig = 1'b1;
    tick();
    chk("in_pend1", pd.pending, 1);
    pd.in_sig = 1'b0;
    tick();
    chk("in_cancel_pend", pd.pending, 0);
    chk("in_cancel_busy", pd.busy, 0);
    run_to(40);
    pd.in_sig = 1'b1;
    expect_at(43, 1'b1);
    run_to(44);
    pd.in_sig = 1'b0;
    expect_at(47, 1'b0);
    run_to(50);
    pd.in_sig = 1'b1;
    run_to(52);
    pd.in_sig = 1'b0;
    tick();
    chk("in_short", pd.pending, 0);
    run_to(58);
    chk("in_short_out", pd.out_sig, 0);
    pd.mode = TRANSPORT;
    pd.delay_cfg = 4'd15;
    run_to(60);
    for (int i = 0; i < 10; i++) begin
      pd.in_sig = (i % 2 == 0);
      if (i < 8) expect_at(75 + i, pd.in_sig);
      tick();
      if (i == 7) begin
        chk("ovf_full_pend", pd.pending, 8);
        chk("ovf_not_yet", pd.ovf, 0);
      end
      if (i == 8) chk("ovf_set", pd.ovf, 1);
    end
    run_to(72);
    pd.ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", pd.ovf, 0);
    pd.ovf_clr = 1'b0;
    run_to(85);
    chk("ovf_drain", pd.pending, 0);
    pd.delay_cfg = 4'd8;
    run_to(90);
    for (int i = 0; i < 10; i++) begin
      pd.in_sig = (i % 2 == 0);
      expect_at(98 + i, pd.in_sig);
      tick();
      if (i == 8) begin
        chk("full_pop_pend", pd.pending, 8);
        chk("full_pop_ovf", pd.ovf, 0);
      end
    end
    run_to(110);
    pd.delay_cfg = 4'd2;
    run_to(115);
    pd.in_sig = 1'b1;
    expect_at(117, 1'b1);
    tick();
    pd.delay_cfg = 4'd5;
    pd.in_sig = 1'b0;
    expect_at(118, 1'b0);
    tick();
    run_to(120);
    pd.in_sig = 1'b1;
    expect_at(125, 1'b1);
    run_to(127);
    pd.delay_cfg = 4'd0;
    run_to(130);
    pd.in_sig = 1'b0;
    expect_at(131, 1'b0);
    run_to(132);
    pd.in_sig = 1'b1;
    expect_at(133, 1'b1);
    run_to(135);
    pd.delay_cfg = 4'd10;
    run_to(137);
    pd.in_sig = 1'b0;
    tick();
    pd.in_sig = 1'b1;
    tick();
    pd.in_sig = 1'b0;
    tick();
    chk("mid_pend3", pd.pending, 3);
    chk("mid_out", pd.out_sig, 1);
    chk("sb_pre_reset", sb.size(), 0);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    prev = 2'b00;
    pd.delay_cfg = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    expect_at(3, 1'b0);
    run_to(6);
    chk("sb_final", sb.size(), 0);
    chk("final_busy", pd.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
